// File: rtl/mp3_stream_arb_pkg.sv
// mp3_stream_arb_pkg: shared constants for the MP3 stream arbiter.
// Contents: FSM state codes, source indices, and a helper that turns a source index into a one-hot grant.
// Build option: MP3_ARB_RR_EN selects round-robin tie-breaking in the top (fixed DMA priority otherwise).
package mp3_stream_arb_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic SRC_DMA = 1'b0;
    localparam logic SRC_CPU = 1'b1;
    function automatic logic [1:0] src_onehot(input logic src);
        return src ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/mp3_stream_arb_if.sv
// mp3_stream_arb_if: byte-source handshakes and decoder serial pins of the MP3 stream arbiter.
// Signals: dma_valid/dma_byte/dma_ready (src 0), cpu_valid/cpu_byte/cpu_ready (src 1),
//          mp3_req (decoder request, async), mp3_clk/mp3_sync/mp3_data (serial output).
// Modports: master = sources and decoder side, slave = the arbiter.
interface mp3_stream_arb_if;
    logic       dma_valid, dma_ready, cpu_valid, cpu_ready;
    logic [7:0] dma_byte, cpu_byte;
    logic       mp3_req, mp3_clk, mp3_sync, mp3_data;
    modport master (
        output dma_valid, dma_byte, cpu_valid, cpu_byte, mp3_req,
        input  dma_ready, cpu_ready, mp3_clk, mp3_sync, mp3_data
    );
    modport slave (
        input  dma_valid, dma_byte, cpu_valid, cpu_byte, mp3_req,
        output dma_ready, cpu_ready, mp3_clk, mp3_sync, mp3_data
    );
endinterface

// File: rtl/mp3_stream_arb_ser.sv
// mp3_stream_arb_ser: serialises one byte MSB-first onto mp3_clk/mp3_sync/mp3_data.
// Ports: clk, rst_n (async, active low), load + din (start a byte), mp3_clk/mp3_sync/mp3_data (registered pins),
//        done (high in the final clk cycle of bit 0).
// Each bit lasts 2*CLK_HALF clk cycles: mp3_clk low for the first CLK_HALF, high for the rest.
module mp3_stream_arb_ser #(
    parameter int CLK_HALF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       mp3_clk,
    output logic       mp3_sync,
    output logic       mp3_data,
    output logic       done
);
    localparam int CW = $clog2(2 * CLK_HALF);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_HALF - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_HALF);
    logic          active;
    logic [CW-1:0] cyc;
    logic [2:0]    idx;
    logic [7:0]    sh;
    assign done = active && cyc == LAST && idx == 3'd0;
    // Pins are registered and only change at a bit boundary while mp3_clk is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            cyc      <= '0;
            idx      <= '0;
            sh       <= '0;
            mp3_clk  <= 1'b0;
            mp3_sync <= 1'b0;
            mp3_data <= 1'b0;
        end else if (load) begin
            active   <= 1'b1;
            cyc      <= '0;
            idx      <= 3'd7;
            sh       <= din;
            mp3_clk  <= 1'b0;
            mp3_sync <= 1'b1;
            mp3_data <= din[7];
        end else if (active) begin
            if (cyc == LAST) begin
                cyc      <= '0;
                idx      <= idx - 3'd1;
                mp3_clk  <= 1'b0;
                mp3_sync <= 1'b0;
                mp3_data <= done ? 1'b0 : sh[idx-3'd1];
                active   <= !done;
            end else begin
                cyc     <= cyc + CW'(1);
                mp3_clk <= (cyc + CW'(1)) >= HALF;
            end
        end
    end
endmodule

// File: rtl/mp3_stream_arb.sv
// mp3_stream_arb: shares the MP3 decoder serial port between SD DMA (src 0) and the CPU (src 1).
// Ports: clk, rst_n (async, active low), bus (mp3_stream_arb_if.slave: source handshakes + decoder pins),
//        busy (not idle), grant (one-hot owner of the byte in flight), byte_cnt (bytes fully sent, wraps).
// Build option: define MP3_ARB_RR_EN for round-robin tie-breaking; otherwise DMA always wins ties.
module mp3_stream_arb
    import mp3_stream_arb_pkg::*;
#(
    parameter int CLK_HALF = 2,
    parameter int IDLE_GAP = 3,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mp3_stream_arb_if.slave      bus,
    output logic                 busy,
    output logic [1:0]           grant,
    output logic [CNT_W-1:0]     byte_cnt
);
    localparam int GW = $clog2(IDLE_GAP + 1);
    logic [1:0]    state;
    logic [GW-1:0] gcnt;
    logic          req_m, req_s, start, win, done;
    logic [7:0]    win_byte;
`ifdef MP3_ARB_RR_EN
    logic last_grant;
    // On a tie the source that did not send the previous byte wins.
    assign win = (bus.dma_valid && bus.cpu_valid) ? (last_grant == SRC_CPU ? SRC_DMA : SRC_CPU)
               : (bus.dma_valid ? SRC_DMA : SRC_CPU);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= SRC_CPU;
        else if (start) last_grant <= win;
    end
`else
    assign win = bus.dma_valid ? SRC_DMA : SRC_CPU;
`endif
    assign start    = state == ST_IDLE && req_s && (bus.dma_valid || bus.cpu_valid);
    assign win_byte = win == SRC_CPU ? bus.cpu_byte : bus.dma_byte;
    assign busy     = state != ST_IDLE;
    mp3_stream_arb_ser #(.CLK_HALF(CLK_HALF)) u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (start),
        .din      (win_byte),
        .mp3_clk  (bus.mp3_clk),
        .mp3_sync (bus.mp3_sync),
        .mp3_data (bus.mp3_data),
        .done     (done)
    );
    // Ready is registered so it rises together with mp3_sync, one clk after the decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m         <= 1'b0;
            req_s         <= 1'b0;
            state         <= ST_IDLE;
            gcnt          <= '0;
            grant         <= 2'b00;
            byte_cnt      <= '0;
            bus.dma_ready <= 1'b0;
            bus.cpu_ready <= 1'b0;
        end else begin
            req_m         <= bus.mp3_req;
            req_s         <= req_m;
            bus.dma_ready <= start && win == SRC_DMA;
            bus.cpu_ready <= start && win == SRC_CPU;
            if (state == ST_IDLE && start) begin
                state <= ST_SHIFT;
                grant <= src_onehot(win);
            end else if (state == ST_SHIFT && done) begin
                state    <= ST_GAP;
                gcnt     <= '0;
                grant    <= 2'b00;
                byte_cnt <= byte_cnt + CNT_W'(1);
            end else if (state == ST_GAP) begin
                state <= gcnt == GW'(IDLE_GAP - 1) ? ST_IDLE : ST_GAP;
                gcnt  <= gcnt + GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mp3_stream_arb.sv
// tb_mp3_stream_arb: scoreboard bench for mp3_stream_arb (reset, single byte, ties, req throttling, mid-byte reset, random, counter wrap).
module tb_mp3_stream_arb;
    import mp3_stream_arb_pkg::*;
    localparam int CH  = 2;
    localparam int GAP = 3;
    localparam int CW  = 4;
`ifdef MP3_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy;
    logic [1:0]    grant;
    logic [CW-1:0] byte_cnt;
    mp3_stream_arb_if bus();
    mp3_stream_arb #(.CLK_HALF(CH), .IDLE_GAP(GAP), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .grant    (grant),
        .byte_cnt (byte_cnt)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0, n_acc = 0, mb = 0, exp_cnt = 0;
    logic [7:0] dma_q[$], cpu_q[$], exp_q[$];
    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask
    task automatic drain(input string name);
        int t = 0;
        while ((dma_q.size() != 0 || cpu_q.size() != 0 || exp_q.size() != 0 || busy || mb != 0) && t < 10000) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({name, "_drain_in_time"}, int'(t < 10000), 1);
    endtask
    // Reference arbiter and source driver: on every accepted byte the winner is derived from the
    // valids that were presented, and the winner's byte is queued as the expected serial output.
    initial begin : model
        int w;
        bit last;
        last = 1'b1;
        bus.dma_valid = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.dma_byte  = 8'h00;
        bus.cpu_byte  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = 1'b1;
            end else if (bus.dma_ready || bus.cpu_ready) begin
                w = (bus.dma_valid && bus.cpu_valid) ? (RR ? (last ? 0 : 1) : 0) : (bus.dma_valid ? 0 : 1);
                chk("ready_src", {bus.cpu_ready, bus.dma_ready}, w ? 2 : 1);
                chk("ready_while_valid", w ? bus.cpu_valid : bus.dma_valid, 1);
                chk("sync_at_accept", {bus.mp3_sync, bus.mp3_clk}, 2);
                chk("grant_at_accept", grant, w ? 2 : 1);
                chk("busy_at_accept", busy, 1);
                if (w == 1 && cpu_q.size() != 0) exp_q.push_back(cpu_q.pop_front());
                else if (w == 0 && dma_q.size() != 0) exp_q.push_back(dma_q.pop_front());
                last = (w == 1);
                n_acc++;
            end
            bus.dma_valid = dma_q.size() != 0;
            bus.dma_byte  = bus.dma_valid ? dma_q[0] : 8'h00;
            bus.cpu_valid = cpu_q.size() != 0;
            bus.cpu_byte  = bus.cpu_valid ? cpu_q[0] : 8'h00;
        end
    end
    // Decoder-side monitor: samples mp3_data on each mp3_clk rise and checks against the scoreboard.
    initial begin : monitor
        bit pclk;
        int slen;
        logic [7:0] sh, e;
        logic [1:0] pg;
        pclk = 1'b0; slen = 0; sh = 8'h00; pg = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mb = 0; slen = 0; pclk = 1'b0; pg = 2'b00; exp_cnt = 0;
                exp_q.delete();
                continue;
            end
            if (bus.mp3_sync) slen++;
            else if (slen != 0) begin
                chk("sync_width", slen, 2 * CH);
                slen = 0;
            end
            if (bus.mp3_clk && !pclk) begin
                chk("sync_on_bit7_only", bus.mp3_sync, int'(mb == 0));
                sh = {sh[6:0], bus.mp3_data};
                mb++;
                if (mb == 8) begin
                    mb = 0;
                    if (exp_q.size() == 0) chk("unexpected_byte", int'(sh), -1);
                    else begin
                        e = exp_q.pop_front();
                        chk("byte", sh, e);
                    end
                end
            end
            if (pg != 2'b00 && grant == 2'b00) begin
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                chk("byte_cnt", byte_cnt, exp_cnt);
                chk("bits_per_byte", mb, 0);
                chk("pins_idle_after_byte", {bus.mp3_clk, bus.mp3_sync, bus.mp3_data}, 0);
            end
            pclk = bus.mp3_clk;
            pg = grant;
        end
    end
    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
    initial begin : stim
        int a0, lat, t;
        bus.mp3_req = 1'b1;
        // Reset with both sources valid: nothing moves until release, then DMA goes first.
        dma_q.push_back(8'hA5);
        cpu_q.push_back(8'h5A);
        repeat (3) @(negedge clk);
        #1;
        chk("reset_valids_high", {bus.dma_valid, bus.cpu_valid}, 3);
        chk("reset_outputs", {busy, grant, byte_cnt, bus.dma_ready, bus.cpu_ready, bus.mp3_clk, bus.mp3_sync, bus.mp3_data}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain("t1");
        chk("t1_cnt", byte_cnt, 2);
        // Tie rounds.
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            dma_q.push_back(8'h11);
            cpu_q.push_back(8'h22);
        end
        drain("t3");
        // Request dropped mid-byte: byte finishes, next waits for req to return.
        @(posedge clk);
        #1;
        a0 = n_acc;
        dma_q.push_back(8'h3C);
        dma_q.push_back(8'hC3);
        t = 0;
        while (n_acc == a0 && t < 200) begin @(negedge clk); #1; t++; end
        chk("t4_first_accept", int'(n_acc == a0 + 1), 1);
        repeat (10) @(negedge clk);
        #1 bus.mp3_req = 1'b0;
        a0 = n_acc;
        repeat (40) @(negedge clk);
        #1;
        chk("t4_no_accept_without_req", n_acc, a0);
        chk("t4_idle_waiting", busy, 0);
        @(posedge clk);
        #1 bus.mp3_req = 1'b1;
        lat = 0;
        while (n_acc == a0 && lat < 20) begin @(negedge clk); #1; lat++; end
        chk("t4_req_latency", int'(lat >= 3 && lat <= 4), 1);
        drain("t4");
        // Reset in the middle of 8'hFF, at bit 4.
        @(posedge clk);
        #1 dma_q.push_back(8'hFF);
        t = 0;
        while (mb != 4 && t < 300) begin @(negedge clk); #1; t++; end
        chk("t5_reached_bit4", mb, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_reset_outputs", {busy, grant, byte_cnt, bus.dma_ready, bus.cpu_ready, bus.mp3_clk, bus.mp3_sync, bus.mp3_data}, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cpu_q.push_back(8'h96);
        drain("t5");
        chk("t5_cnt", byte_cnt, 1);
        // Randomised traffic with random req throttling; total volume wraps byte_cnt several times.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 24) == 0) dma_q.push_back(8'($urandom));
            if ($urandom_range(0, 24) == 0) cpu_q.push_back(8'($urandom));
            if ($urandom_range(0, 59) == 0) bus.mp3_req = ~bus.mp3_req;
        end
        bus.mp3_req = 1'b1;
        drain("rand");
        // Explicit wrap past 2^CW-1.
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) dma_q.push_back(8'(i * 37));
        drain("wrap");
        chk("wrap_cnt", byte_cnt, exp_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
